lsu_data_port: RTL
==================

# lsu_data_port

Load/store unit for the writeback stage of the three-stage pipeline. It converts the stage's load/store request into a handshaked data-bus transaction and holds the pipeline while the access is in flight. It sign- or zero-extends load data and raises `loaded` once the result is ready, which is the completion signal the hazard unit uses to release its load-use stall. It sits between the writeback-stage control and the data memory / bus interconnect.

## Interface
Parameters:
- `XLEN`, 32, data and address width; only 32 is supported.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `mem_read`  in  1  the writeback-stage instruction is a load.
- `mem_write`  in  1  the writeback-stage instruction is a store.
- `funct3`  in  3  access size and signedness (RV32I encoding).
- `addr`  in  32  effective byte address.
- `wdata`  in  32  store data, right-aligned.
- `advance`  in  1  the pipeline moves the writeback instruction on this edge.
- `dbus_req`  out  1  bus request valid.
- `dbus_we`  out  1  bus write enable.
- `dbus_addr`  out  32  word-aligned bus address, `{addr[31:2],2'b00}`.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_wstrb`  out  4  byte-lane strobes; all zero on reads.
- `dbus_ack`  in  1  bus transfer complete; `dbus_rdata` is valid in the same cycle.
- `dbus_rdata`  in  32  bus read data.
- `busy`  out  1  the access is not yet complete; the pipeline must stall.
- `loaded`  out  1  the access is complete; `load_data` is valid.
- `load_data`  out  32  extended load result.
- `misalign_ld`  out  1  misaligned-load trap (configurable).
- `misalign_st`  out  1  misaligned-store trap (configurable).

## Operation
- The FSM has three states: IDLE, REQ, DONE.
- IDLE → REQ when the access is valid: (`mem_read` | `mem_write`) and not misaligned-trapped.
  - On that edge, latch the transaction: `we`, word address, wdata, wstrb, `funct3`, `addr[1:0]`.
  - If both `mem_read` and `mem_write` are high, treat it as a load.
- REQ: `dbus_req`=1 and the latched fields drive the bus.
  - On an edge with `dbus_ack`=1, capture the extended `dbus_rdata` into `load_data` and go to DONE.
  - Otherwise stay in REQ.
- DONE: `loaded`=1 and `load_data` is held.
  - Go to IDLE on an edge with `advance`=1; otherwise stay in DONE.
  - DONE never re-issues the access, even though the same instruction is still presented.
- `busy` = (REQ) | (IDLE & valid access).
  - It is combinational so the first cycle stalls.
  - In DONE, `busy`=0.
- Load extension uses byte lane `addr[1:0]`:
  - LB 000: sign-extend byte.
  - LH 001: sign-extend the half at `addr[1]`.
  - LW 010: whole word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend the half.
  - Reserved 011/110/111: treated as LW.
- Store lanes:
  - SB: `wstrb` = 0001<<`addr[1:0]`, wdata byte replicated ×4.
  - SH: `wstrb` = 0011<<{`addr[1]`,0}, half replicated ×2.
  - SW: `wstrb` = 1111.
- `loaded` is asserted for stores as well; `load_data` is then don't-care and is left unchanged.
- A `dbus_ack` seen in IDLE or DONE is ignored.

## Timing
- Reset (`rst` high on an edge) sets:
  - State to IDLE.
  - `dbus_req`, `dbus_we`, `loaded`, `misalign_ld`, `misalign_st` to 0.
  - `dbus_addr`, `dbus_wdata`, `dbus_wstrb`, `load_data` to 0.
- Reset mid-transaction (REQ or DONE) aborts to IDLE; `dbus_req` drops the next cycle.
- Bus rule: from the cycle `dbus_req` rises until the ack edge, `dbus_req`, `dbus_we`, `dbus_addr`, `dbus_wdata`, `dbus_wstrb` are stable.
- Minimum latency with zero-wait memory (ack in the first REQ cycle):
  - Cycle 0: IDLE, request seen.
  - Cycle 1: REQ, ack.
  - Cycle 2: DONE, `loaded`=1.
- Each cycle without ack adds one cycle.
- Back-to-back: after DONE with `advance`=1, the next access can start from IDLE in the following cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned conditions: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0.
  - In IDLE, such an access drives `misalign_ld` or `misalign_st` high combinationally.
  - It issues no bus request, asserts no `busy`, and never enters REQ.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign_ld` and `misalign_st` are tied 0.
  - Offending address low bits are ignored: halves use `addr[1]` only, words use lane 0.
  - The access proceeds normally.

## Test plan
- LW, `addr`=0x104, memory word 0x8899AABB, ack on the first REQ cycle → `dbus_addr`=0x104, `wstrb`=0000; `loaded`=1 in cycle 2; `load_data`=0x8899AABB.
- LB/LBU at `addr`=0x107 with rdata 0x80FFFF7F, 3 wait states → LB gives 0xFFFFFF80 and LBU gives 0x00000080; `busy` high for exactly 5 cycles.
- SB `wdata`=0x12345678 at `addr`=0x202 → `dbus_addr`=0x200, `wstrb`=0100, `dbus_wdata`=0x78787878, `we`=1.
- DONE held with `advance`=0 for 4 cycles → `loaded` stays 1 for 4 cycles and exactly one bus transaction occurs.
- `rst` asserted while in REQ → the next cycle is IDLE with `dbus_req`=0 and `loaded`=0; a later stray `dbus_ack` changes nothing.
- LW at `addr`=0x102:
  - With the macro: `misalign_ld`=1, `busy`=0, no `dbus_req`.
  - Without the macro: the load completes from word 0x100.

Source files
------------

// File: rtl/lsu_data_port.sv
// rtl/lsu_data_port.sv - writeback-stage load/store unit driving a handshaked data bus
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module lsu_data_port #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            advance,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_wstrb,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            busy,
    output logic            loaded,
    output logic [XLEN-1:0] load_data,
    output logic            misalign_ld,
    output logic            misalign_st
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_next;

    logic            is_store;
    logic            is_half;
    logic            is_word;
    logic            trap;
    logic            access_valid;
    logic [3:0]      st_strb;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_ext;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [2:0]      funct3_q;
    logic [1:0]      lane_q;

    // A simultaneous read and write request is handled as a load.
    assign is_store = mem_write & ~mem_read;
    assign is_half  = (funct3[1:0] == 2'b01);
    assign is_word  = funct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned  = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign misalign_ld = (state == IDLE) & mem_read & misaligned;
    assign misalign_st = (state == IDLE) & is_store & misaligned;
`else
    assign misalign_ld = 1'b0;
    assign misalign_st = 1'b0;
`endif

    assign trap         = misalign_ld | misalign_st;
    assign access_valid = (mem_read | mem_write) & ~trap;

    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = dbus_rdata[7:0];
        case (lane_q)
            2'b00: ld_byte = dbus_rdata[7:0];
            2'b01: ld_byte = dbus_rdata[15:8];
            2'b10: ld_byte = dbus_rdata[23:16];
            2'b11: ld_byte = dbus_rdata[31:24];
            default: ld_byte = dbus_rdata[7:0];
        endcase
        ld_half = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = dbus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access_valid) state_next = REQ;
            REQ:     if (dbus_ack)     state_next = DONE;
            DONE:    if (advance)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction fields are frozen on the IDLE->REQ edge so the bus sees stable values until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 4'b0;
            funct3_q  <= 3'b0;
            lane_q    <= 2'b0;
            load_data <= '0;
        end else begin
            if (state == IDLE && access_valid) begin
                we_q     <= is_store;
                addr_q   <= {addr[XLEN-1:2], 2'b00};
                wdata_q  <= st_wdata;
                wstrb_q  <= is_store ? st_strb : 4'b0000;
                funct3_q <= funct3;
                lane_q   <= addr[1:0];
            end
            if (state == REQ && dbus_ack && !we_q) begin
                load_data <= ld_ext;
            end
        end
    end

    assign dbus_req   = (state == REQ);
    assign dbus_we    = (state == REQ) & we_q;
    assign dbus_addr  = addr_q;
    assign dbus_wdata = wdata_q;
    assign dbus_wstrb = wstrb_q;
    assign loaded     = (state == DONE);
    assign busy       = (state == REQ) | ((state == IDLE) & access_valid);

endmodule
